// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared definitions for the load/store unit. Holds the RV32I
//               funct3 width codes, the FSM state encoding and the legality
//               check applied to an incoming request.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  // funct3 width/sign codes. Loads and stores share the low codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  // Returns 1 for any request that must be rejected without a bus access:
  // reserved width codes, unsigned stores, or addresses not naturally aligned
  // to the access size.
  function automatic logic lsu_illegal(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
      bad = 1'b1;
    end else if (is_store && funct3[2]) begin
      bad = 1'b1;
    end else if ((funct3 == F3_LH || funct3 == F3_LHU) && addr_lo[0]) begin
      bad = 1'b1;
    end else if (funct3 == F3_LW && addr_lo != 2'b00) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load formatter. Picks the byte/halfword lane
//               addressed by addr[1:0] out of the memory word and sign- or
//               zero-extends it according to funct3.
// Ports       : rdata    in  32  word returned by data memory
//               addr     in   2  byte offset within the word
//               funct3   in   3  load width/sign code
//               ext_data out 32  extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  // Moving the addressed lane down to bit 0 lets every width read the low bits.
  logic [31:0] shifted;
  assign shifted = rdata >> {addr, 3'b000};

  always_comb begin
    ext_data = shifted;
    case (funct3)
      F3_LB:   ext_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   ext_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  ext_data = {24'd0, shifted[7:0]};
      F3_LHU:  ext_data = {16'd0, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I data-memory access stage. Issues one outstanding
//               req/ack access per request, formats store lanes, extends
//               load data and reports misaligned/illegal ops and timeouts.
// Ports       : clk, rst_n                 clock, async active-low reset
//               start, is_store, funct3,   request from EX (sampled when idle)
//               addr, store_data
//               busy, done, load_data,     pipeline handshake and results
//               misaligned, bus_err
//               mem_req, mem_we, mem_addr, data-memory port
//               mem_be, mem_wdata,
//               mem_rdata, mem_ack
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e       state;
  lsu_state_e       state_next;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic             misaligned_q;
  logic             bus_err_q;
  logic             accept;
  logic             illegal;
  logic             ack_ok;
  logic             timed_out;
  logic [3:0]       be_fmt;
  logic [31:0]      wdata_fmt;
  logic [31:0]      aligned;

  // DONE is treated as idle for acceptance so accesses can run back to back.
  assign accept    = start && (state == ST_IDLE || state == ST_DONE);
  assign illegal   = lsu_illegal(is_store, funct3, addr[1:0]);
  assign ack_ok    = (state == ST_ACCESS) && mem_ack;
  // An ack in the same cycle the counter reaches the limit wins over timeout.
  assign timed_out = (state == ST_ACCESS) && !mem_ack && (cycle_cnt == CNT_W'(TIMEOUT));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = start;
        if (start) begin
          state_next = illegal ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (ack_ok || timed_out) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy = start;
        done = 1'b1;
        if (start) begin
          state_next = illegal ? ST_DONE : ST_ACCESS;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Error qualifiers are only meaningful alongside done.
  assign misaligned = done && misaligned_q;
  assign bus_err    = done && bus_err_q;

  // --------------------------------------------------------------------------
  // Store formatting: byte enables and lane-replicated write data
  // --------------------------------------------------------------------------
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = store_data;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          be_fmt    = 4'b0001 << addr[1:0];
          wdata_fmt = {4{store_data[7:0]}};
        end
        F3_SH: begin
          be_fmt    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_fmt = {2{store_data[15:0]}};
        end
        F3_SW: begin
          be_fmt    = 4'b1111;
          wdata_fmt = store_data;
        end
        default: begin
          be_fmt    = 4'b1111;
          wdata_fmt = store_data;
        end
      endcase
    end
  end

  lsu_load_align u_load_align (
    .rdata    (mem_rdata),
    .addr     (addr_lo_q),
    .funct3   (funct3_q),
    .ext_data (aligned)
  );

  // --------------------------------------------------------------------------
  // Request registers, timeout counter and load result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_be       <= 4'd0;
      mem_wdata    <= 32'd0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cycle_cnt    <= '0;
      load_data    <= 32'd0;
    end else begin
      if (accept) begin
        misaligned_q <= illegal;
        bus_err_q    <= 1'b0;
        // The counter holds the 1-based index of the current ACCESS cycle.
        cycle_cnt    <= CNT_W'(1);
        if (!illegal) begin
          mem_we    <= is_store;
          mem_addr  <= {addr[31:2], 2'b00};
          mem_be    <= be_fmt;
          mem_wdata <= wdata_fmt;
          funct3_q  <= funct3;
          addr_lo_q <= addr[1:0];
        end
      end else if (state == ST_ACCESS && !ack_ok && !timed_out) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end

      if (timed_out) begin
        bus_err_q <= 1'b1;
      end

      if (ack_ok && !mem_we) begin
        load_data <= aligned;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A driver issues
//               directed and random requests, a memory responder checks the
//               bus and returns data, and a monitor compares each completion
//               against expectations queued by the driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack   = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model (pure arithmetic on the instruction semantics)
  // --------------------------------------------------------------------------
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 0;
    if (st && f3 >= 4) return 0;
    return (a % size_of(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int sz;
    int off;
    logic [31:0] v;
    sz  = size_of(f3);
    off = a % 4;
    v   = rd >> (8 * off);
    if (sz == 4) return v;
    v = v & ((32'd1 << (8 * sz)) - 32'd1);
    if (f3 < 4 && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int m;
    if (!st) return 4'hF;
    m = ((1 << size_of(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (size_of(f3))
      1:       return {24'd0, sd[7:0]} * 32'h01010101;
      2:       return {16'd0, sd[15:0]} * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  typedef struct {
    bit          mis;
    bit          berr;
    logic [31:0] ld;
  } exp_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
    bit          we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } resp_t;

  exp_t        exp_q[$];
  resp_t       resp_q[$];
  logic [31:0] model_ld = 32'd0;

  // --------------------------------------------------------------------------
  // Monitor: compares every completion against the queued expectation
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual=1 required=0 at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
          check("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
          check("load_data", load_data, e.ld);
        end
      end else begin
        check("flags_without_done", {30'd0, misaligned, bus_err}, 32'd0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory responder: checks bus fields, acks after the planned delay
  // --------------------------------------------------------------------------
  resp_t cur;
  int    resp_cnt   = 0;
  bit    serving    = 0;
  bit    pend_done  = 0;
  bit    pend_berr  = 0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      serving   = 0;
      pend_done = 0;
      mem_ack   = 1'b0;
    end else begin
      if (pend_done) begin
        check("done_latency", {31'd0, done}, 32'd1);
        check("done_bus_err", {31'd0, bus_err}, {31'd0, pend_berr});
        pend_done = 0;
      end
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (!serving) begin
          if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: actual=1 required=0 at %0t", $time);
            cur.delay = 1; cur.rdata = 32'd0; cur.we = mem_we;
            cur.maddr = mem_addr; cur.be = mem_be; cur.wdata = mem_wdata;
          end else begin
            cur = resp_q.pop_front();
          end
          serving  = 1;
          resp_cnt = 0;
        end
        resp_cnt++;
        check("busy_in_access", {31'd0, busy}, 32'd1);
        check("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
        check("mem_addr", mem_addr, cur.maddr);
        check("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
        if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        if (resp_cnt == cur.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = cur.rdata;
          pend_done = 1;
          pend_berr = 0;
        end else if (resp_cnt == TIMEOUT) begin
          pend_done = 1;
          pend_berr = 1;
        end
      end else begin
        serving = 0;
        // Stray acks outside an access must be ignored by the DUT.
        if ($urandom_range(0, 3) == 0) mem_ack = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver. Called at a falling edge while the DUT can accept; returns at the
  // falling edge of the done cycle so the next call can go back to back.
  // A delay above TIMEOUT means the responder never acks.
  // --------------------------------------------------------------------------
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int delay, input logic [31:0] rd,
                         input bit junk);
    bit    ok;
    bit    succ;
    resp_t r;
    exp_t  e;
    ok   = legal(st, f3, a);
    succ = ok && delay >= 1 && delay <= TIMEOUT;
    if (ok) begin
      r.delay = delay; r.rdata = rd; r.we = st; r.maddr = {a[31:2], 2'b00};
      r.be = ref_be(st, f3, a); r.wdata = ref_wdata(f3, sd);
      resp_q.push_back(r);
    end
    if (succ && !st) model_ld = ref_load(f3, a, rd);
    e.mis = !ok; e.berr = ok && !succ; e.ld = model_ld;
    exp_q.push_back(e);

    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    #1;
    check("busy_start", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0; is_store = $urandom_range(0, 1); funct3 = 3'($urandom);
    addr = $urandom; store_data = $urandom;
    @(negedge clk);
    check("req_cycle1", {31'd0, mem_req}, {31'd0, ok});
    if (!ok) begin
      check("illegal_done_cycle1", {31'd0, done}, 32'd1);
      check("illegal_busy_cycle1", {31'd0, busy}, 32'd0);
    end else begin
      for (int n = 0; n < TIMEOUT + 3; n++) begin
        if (n > 0) @(negedge clk);
        start = 1'b0;
        if (done) break;
        if (junk && n == 0 && mem_req) begin
          start = 1'b1; is_store = $urandom_range(0, 1); funct3 = 3'($urandom_range(0, 2));
          addr = $urandom & 32'hFFFF_FFFC;
        end
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL done_wait: actual=0 required=1 at %0t", $time);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_flags", {30'd0, misaligned, bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn(0, 3'b010, 32'h100, 32'd0, 3, 32'hDEADBEEF, 0);
    run_txn(0, 3'b000, 32'h103, 32'd0, 2, 32'h80FF0000, 0);
    @(negedge clk);
    run_txn(0, 3'b100, 32'h103, 32'd0, 1, 32'h80FF0000, 0);
    run_txn(0, 3'b101, 32'h102, 32'd0, 2, 32'h80011234, 0);
    run_txn(1, 3'b001, 32'h206, 32'h0000ABCD, 2, 32'd0, 0);
    run_txn(1, 3'b010, 32'h101, 32'h11111111, 1, 32'd0, 0);
    @(negedge clk);
    run_txn(0, 3'b011, 32'h100, 32'd0, 1, 32'd0, 0);
    run_txn(0, 3'b010, 32'h300, 32'd0, TIMEOUT + 1, 32'hCAFEF00D, 0);
    run_txn(0, 3'b010, 32'h300, 32'd0, TIMEOUT, 32'h12345678, 0);
    run_txn(1, 3'b000, 32'h401, 32'h000000A5, 3, 32'd0, 1);
    run_txn(0, 3'b001, 32'h402, 32'd0, 2, 32'h7FFF8000, 1);

    // Random traffic with random gaps
    for (int i = 0; i < 200; i++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = $urandom_range(0, 1);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
           (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(st, f3, a, $urandom, $urandom_range(1, TIMEOUT + 1), $urandom,
              $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of an access
    @(negedge clk);
    begin
      resp_t r;
      r.delay = TIMEOUT + 1; r.rdata = 32'd0; r.we = 1'b0; r.maddr = 32'h500;
      r.be = 4'hF; r.wdata = 32'd0;
      resp_q.push_back(r);
    end
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_req_before_rst", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    resp_q.delete();
    model_ld = 32'd0;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_done", {31'd0, done}, 32'd0);
    end
    check("post_rst_load_data", load_data, 32'd0);
    run_txn(0, 3'b000, 32'h600, 32'd0, 1, 32'h0000007F, 0);
    run_txn(0, 3'b010, 32'h604, 32'd0, 2, 32'hA5A55A5A, 0);
    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("resp_q_drained", resp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
